// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters, one op in flight.
// Optional op counter output ops_done enabled by defining ALU_ARB_STATS_EN.
module alu_req_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned SEL_W   = 4,
   parameter int unsigned ALU_LAT = 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]    req_a,
   input  logic [NUM_REQ*DATA_W-1:0]    req_b,
   input  logic [NUM_REQ*SEL_W-1:0]     req_sel,
   output logic [DATA_W-1:0]            alu_a,
   output logic [DATA_W-1:0]            alu_b,
   output logic [SEL_W-1:0]             alu_selection,
   input  logic [DATA_W-1:0]            alu_result,
   input  logic                         alu_carry_out,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
   output logic [DATA_W-1:0]            rsp_result,
   output logic                         rsp_carry,
   output logic                         busy
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0]                  ops_done
`endif
);

   localparam int unsigned ID_W  = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   grant_q, grant_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
   logic              rsp_valid_q, rsp_valid_d, rsp_carry_q, rsp_carry_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0] rsp_result_q, rsp_result_d;

   logic              found;
   logic [ID_W-1:0]   grant_idx;
   logic [ID_W:0]     cand;
   logic              grant_en;

   // First valid requester at or after rr_ptr, wrapping mod NUM_REQ.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
         if (!found && req_valid[cand[ID_W-1:0]]) begin
            found     = 1'b1;
            grant_idx = cand[ID_W-1:0];
         end
      end
   end

   // Held low while in reset so no grant is advertised before the FSM can take it.
   assign grant_en = found && (state_q == StIdle) && reset;

   always_comb begin
      req_ready = '0;
      if (grant_en) req_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      grant_d      = grant_q;
      wait_cnt_d   = wait_cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_sel_d    = alu_sel_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_carry_d  = rsp_carry_q;
      unique case (state_q)
         StIdle: begin
            if (grant_en) begin
               alu_a_d    = req_a[grant_idx*DATA_W +: DATA_W];
               alu_b_d    = req_b[grant_idx*DATA_W +: DATA_W];
               alu_sel_d  = req_sel[grant_idx*SEL_W +: SEL_W];
               grant_d    = grant_idx;
               rr_ptr_d   = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
               wait_cnt_d = CNT_W'(ALU_LAT-1);
               state_d    = StWait;
            end
         end
         StWait: begin
            if (wait_cnt_q == '0) begin
               rsp_result_d = alu_result;
               rsp_carry_d  = alu_carry_out;
               rsp_id_d     = grant_q;
               rsp_valid_d  = 1'b1;
               state_d      = StResp;
            end else begin
               wait_cnt_d = wait_cnt_q - 1'b1;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         rr_ptr_q     <= '0;
         grant_q      <= '0;
         wait_cnt_q   <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_sel_q    <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_carry_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_q      <= grant_d;
         wait_cnt_q   <= wait_cnt_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_sel_q    <= alu_sel_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_carry_q  <= rsp_carry_d;
      end
   end

   assign alu_a         = alu_a_q;
   assign alu_b         = alu_b_q;
   assign alu_selection = alu_sel_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_id        = rsp_id_q;
   assign rsp_result    = rsp_result_q;
   assign rsp_carry     = rsp_carry_q;
   assign busy          = (state_q != StIdle);

`ifdef ALU_ARB_STATS_EN
   logic [15:0] ops_done_q;

   // Saturating count of completed response handshakes.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ops_done_q <= '0;
      end else if (state_q == StResp && rsp_ready && ops_done_q != 16'hFFFF) begin
         ops_done_q <= ops_done_q + 16'd1;
      end
   end

   assign ops_done = ops_done_q;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed self-checking bench for alu_req_arbiter with a simple adder standing in as the ALU.
module tb_alu_req_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 8;
   localparam int SEL_W   = 4;

   logic                      clock = 1'b0;
   logic                      reset = 1'b0;
   logic [NUM_REQ-1:0]        req_valid = '0;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*DATA_W-1:0] req_a = '0;
   logic [NUM_REQ*DATA_W-1:0] req_b = '0;
   logic [NUM_REQ*SEL_W-1:0]  req_sel = '0;
   logic [DATA_W-1:0]         alu_a, alu_b, alu_result;
   logic [SEL_W-1:0]          alu_selection;
   logic                      alu_carry_out;
   logic                      rsp_valid;
   logic                      rsp_ready = 1'b0;
   logic [1:0]                rsp_id;
   logic [DATA_W-1:0]         rsp_result;
   logic                      rsp_carry;
   logic                      busy;
`ifdef ALU_ARB_STATS_EN
   logic [15:0]               ops_done;
`endif

   int n_vec = 0;
   int n_err = 0;

   alu_req_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .SEL_W(SEL_W), .ALU_LAT(1)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_selection(alu_selection),
      .alu_result(alu_result), .alu_carry_out(alu_carry_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_carry(rsp_carry), .busy(busy)
`ifdef ALU_ARB_STATS_EN
      , .ops_done(ops_done)
`endif
   );

   always #5 clock = ~clock;

   assign {alu_carry_out, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] sel);
      req_a[i*DATA_W +: DATA_W] = a;
      req_b[i*DATA_W +: DATA_W] = b;
      req_sel[i*SEL_W +: SEL_W] = sel;
   endtask

   task automatic do_reset();
      reset = 1'b0; req_valid = '0; rsp_ready = 1'b0;
      @(negedge clock); @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; req_valid = 4'hF; rsp_ready = 1'b0;
      @(negedge clock); @(negedge clock);
      n_vec++;
      if (req_ready !== 4'b0000) begin
         n_err++; $display("FAIL reset_req_ready: got %b want 0000", req_ready);
      end
      n_vec++;
      if ({rsp_valid, busy, rsp_carry} !== 3'b000) begin
         n_err++; $display("FAIL reset_flags: got %b want 000", {rsp_valid, busy, rsp_carry});
      end
      n_vec++;
      if ({alu_a, alu_b, alu_selection, rsp_id, rsp_result} !== 30'd0) begin
         n_err++; $display("FAIL reset_regs: got %h want 0",
                           {alu_a, alu_b, alu_selection, rsp_id, rsp_result});
      end
      req_valid = '0;
      reset = 1'b1;
   endtask

   task automatic test_single_op();
      do_reset();
      set_req(2, 8'h0F, 8'h01, 4'h0);
      req_valid = 4'b0100;
      #1;
      n_vec++;
      if (req_ready !== 4'b0100) begin
         n_err++; $display("FAIL single_grant: got %b want 0100", req_ready);
      end
      @(negedge clock);
      n_vec++;
      if ({req_ready, busy, rsp_valid} !== 6'b0000_10) begin
         n_err++; $display("FAIL single_wait_flags: got %b want 000010",
                           {req_ready, busy, rsp_valid});
      end
      n_vec++;
      if ({alu_a, alu_b, alu_selection} !== {8'h0F, 8'h01, 4'h0}) begin
         n_err++; $display("FAIL single_alu_in: got %h want 0f010", {alu_a, alu_b, alu_selection});
      end
      req_valid = '0;
      @(negedge clock);
      n_vec++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_carry} !== {1'b1, 2'd2, 8'h10, 1'b0}) begin
         n_err++; $display("FAIL single_rsp: got v=%b id=%0d r=%h c=%b want v=1 id=2 r=10 c=0",
                           rsp_valid, rsp_id, rsp_result, rsp_carry);
      end
      rsp_ready = 1'b1;
      @(negedge clock);
      n_vec++;
      if ({rsp_valid, busy, alu_a} !== {1'b0, 1'b0, 8'h0F}) begin
         n_err++; $display("FAIL single_done: got v=%b busy=%b alu_a=%h want 0 0 0f",
                           rsp_valid, busy, alu_a);
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_round_robin();
      int e;
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'(16*i+3), 8'(i+1), 4'(i+8));
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      for (int n = 0; n < 6; n++) begin
         e = n % 4;
         #1;
         n_vec++;
         if (req_ready !== 4'(1 << e)) begin
            n_err++; $display("FAIL rr_grant%0d: got %b want %b", n, req_ready, 4'(1 << e));
         end
         @(negedge clock);
         n_vec++;
         if ({alu_a, alu_selection} !== {8'(16*e+3), 4'(e+8)}) begin
            n_err++; $display("FAIL rr_alu%0d: got %h/%h want %h/%h", n, alu_a, alu_selection,
                              8'(16*e+3), 4'(e+8));
         end
         @(negedge clock);
         n_vec++;
         if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'(e), 8'(17*e+4)}) begin
            n_err++; $display("FAIL rr_rsp%0d: got v=%b id=%0d r=%h want v=1 id=%0d r=%h", n,
                              rsp_valid, rsp_id, rsp_result, e, 8'(17*e+4));
         end
         @(negedge clock);
      end
      req_valid = '0;
      rsp_ready = 1'b0;
   endtask

   task automatic test_pointer_wrap();
      do_reset();
      rsp_ready = 1'b1;
      req_valid = 4'b1000;
      #1;
      n_vec++;
      if (req_ready !== 4'b1000) begin
         n_err++; $display("FAIL wrap_grant3: got %b want 1000", req_ready);
      end
      @(negedge clock);
      req_valid = 4'b0010;
      @(negedge clock); @(negedge clock);
      #1;
      n_vec++;
      if (req_ready !== 4'b0010) begin
         n_err++; $display("FAIL wrap_grant1: got %b want 0010", req_ready);
      end
      @(negedge clock);
      req_valid = 4'hF;
      @(negedge clock); @(negedge clock);
      #1;
      n_vec++;
      if (req_ready !== 4'b0100) begin
         n_err++; $display("FAIL wrap_grant2: got %b want 0100", req_ready);
      end
      req_valid = '0;
      rsp_ready = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_backpressure();
      do_reset();
      set_req(0, 8'hF0, 8'h20, 4'h5);
      req_valid = 4'b0001;
      #1;
      n_vec++;
      if (req_ready !== 4'b0001) begin
         n_err++; $display("FAIL bp_grant: got %b want 0001", req_ready);
      end
      @(negedge clock);
      req_valid = 4'hF;
      @(negedge clock);
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         n_vec++;
         if ({rsp_valid, rsp_id, rsp_result, rsp_carry, req_ready, alu_a, alu_b, alu_selection}
             !== {1'b1, 2'd0, 8'h10, 1'b1, 4'b0000, 8'hF0, 8'h20, 4'h5}) begin
            n_err++; $display("FAIL bp_hold%0d: got v=%b id=%0d r=%h c=%b rdy=%b a=%h b=%h s=%h",
                              c, rsp_valid, rsp_id, rsp_result, rsp_carry, req_ready, alu_a,
                              alu_b, alu_selection);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clock);
      #1;
      n_vec++;
      if ({rsp_valid, req_ready} !== {1'b0, 4'b0010}) begin
         n_err++; $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=0010",
                           rsp_valid, req_ready);
      end
      req_valid = '0;
      rsp_ready = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      set_req(2, 8'h33, 8'h44, 4'h1);
      req_valid = 4'b0100;
      rsp_ready = 1'b1;
      @(negedge clock);
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++; $display("FAIL midrst_busy_before: got %b want 1", busy);
      end
      reset = 1'b0;
      req_valid = 4'hF;
      #1;
      n_vec++;
      if ({rsp_valid, busy, req_ready, alu_a} !== {1'b0, 1'b0, 4'b0000, 8'h00}) begin
         n_err++; $display("FAIL midrst_abort: got v=%b busy=%b rdy=%b a=%h want 0 0 0000 00",
                           rsp_valid, busy, req_ready, alu_a);
      end
      @(negedge clock);
      n_vec++;
      if (rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL midrst_no_rsp: got %b want 0", rsp_valid);
      end
      reset = 1'b1;
      #1;
      n_vec++;
      if (req_ready !== 4'b0001) begin
         n_err++; $display("FAIL midrst_ptr: got %b want 0001", req_ready);
      end
      req_valid = '0;
      rsp_ready = 1'b0;
      @(negedge clock);
   endtask

`ifdef ALU_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      #1;
      n_vec++;
      if (ops_done !== 16'd0) begin
         n_err++; $display("FAIL stats_reset: got %h want 0000", ops_done);
      end
      rsp_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         req_valid = 4'b0001;
         @(negedge clock);
         req_valid = '0;
         @(negedge clock); @(negedge clock);
      end
      @(negedge clock);
      n_vec++;
      if (ops_done !== 16'd3) begin
         n_err++; $display("FAIL stats_three: got %h want 0003", ops_done);
      end
      force dut.ops_done_q = 16'hFFFF;
      @(negedge clock);
      release dut.ops_done_q;
      req_valid = 4'b0001;
      @(negedge clock);
      req_valid = '0;
      @(negedge clock); @(negedge clock); @(negedge clock);
      n_vec++;
      if (ops_done !== 16'hFFFF) begin
         n_err++; $display("FAIL stats_saturate: got %h want ffff", ops_done);
      end
      rsp_ready = 1'b0;
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_op();
      test_round_robin();
      test_pointer_wrap();
      test_backpressure();
      test_reset_mid_wait();
`ifdef ALU_ARB_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
